// File: rtl/addr_stack.sv
//==============================================================================
// Module   : addr_stack
// Purpose  : 16-bit hardware LIFO for the memory-mapped address-stack slot,
//            with a registered top-of-stack and sticky overflow/underflow flags.
//            Define ADDR_STACK_WRAP_EN to make the stack circular.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module addr_stack #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             clearFlags,
    input  logic [15:0]      dataIn,
    output logic [15:0]      dataOut,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DATA_W   = 16;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] top_q, top_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              w_mem_we;
    logic [PTR_W-1:0]  w_mem_waddr;
    logic [PTR_W-1:0]  w_base;
    logic [PTR_W-1:0]  w_idx_push;
    logic [PTR_W-1:0]  w_idx_top;
    logic [PTR_W-1:0]  w_idx_below;
    logic              w_is_empty;
    logic              w_is_full;
    logic              w_ovf_evt;
    logic              w_unf_evt;

`ifdef ADDR_STACK_WRAP_EN
    // Physical slot of the oldest live entry; advances when a full push overwrites it.
    logic [PTR_W-1:0]  bot_q, bot_d;
    assign w_base = bot_q;
`else
    assign w_base = '0;
`endif

    assign w_is_empty  = (count_q == '0);
    assign w_is_full   = (count_q == CNT_FULL);

    // Logical positions are relative to the bottom; all indices wrap mod DEPTH.
    assign w_idx_push  = w_base + count_q[PTR_W-1:0];
    assign w_idx_top   = w_idx_push - PTR_W'(1);
    assign w_idx_below = w_idx_push - PTR_W'(2);

    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = w_idx_push;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
`ifdef ADDR_STACK_WRAP_EN
        bot_d       = bot_q;
`endif

        if (push && pop && !w_is_empty) begin
            // Replace-top: depth unchanged, so no flag can fire even when full.
            w_mem_we    = 1'b1;
            w_mem_waddr = w_idx_top;
            top_d       = dataIn;
        end else if (push) begin
            if (!w_is_full) begin
                w_mem_we = 1'b1;
                count_d  = count_q + CNT_ONE;
                top_d    = dataIn;
            end else begin
`ifdef ADDR_STACK_WRAP_EN
                // When full, w_idx_push equals the bottom slot: overwrite oldest.
                w_mem_we = 1'b1;
                bot_d    = bot_q + PTR_W'(1);
                top_d    = dataIn;
`else
                w_ovf_evt = 1'b1;
`endif
            end
        end else if (pop) begin
            if (w_is_empty) begin
                w_unf_evt = 1'b1;
            end else if (count_q == CNT_ONE) begin
                count_d = '0;
                top_d   = '0;
            end else begin
                count_d = count_q - CNT_ONE;
                top_d   = mem_q[w_idx_below];
            end
        end

        ovf_d = (ovf_q & ~clearFlags) | w_ovf_evt;
        unf_d = (unf_q & ~clearFlags) | w_unf_evt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef ADDR_STACK_WRAP_EN
            bot_q   <= '0;
`endif
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef ADDR_STACK_WRAP_EN
            bot_q   <= bot_d;
`endif
        end
    end

    // Storage is not reset; a coincident reset still suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RST && w_mem_we) begin
            mem_q[w_mem_waddr] <= dataIn;
        end
    end

    assign dataOut   = top_q;
    assign count     = count_q;
    assign empty     = w_is_empty;
    assign full      = w_is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_addr_stack.sv
//==============================================================================
// Module   : tb_addr_stack
// Purpose  : Directed self-checking bench for addr_stack (DEPTH=32).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_addr_stack;

    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic              CLK;
    logic              RST;
    logic              push;
    logic              pop;
    logic              clearFlags;
    logic [15:0]       dataIn;
    logic [15:0]       dataOut;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    addr_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .pop        (pop),
        .clearFlags (clearFlags),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic c, input logic [15:0] d, input int n,
                                input logic [15:0] o, input logic e, input logic f,
                                input logic ov, input logic un);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.clr = c; v.din = d;
        v.cnt = n; v.dout = o; v.emp = e; v.ful = f; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of strobes, then sample just after the capturing edge.
    task automatic step(input logic r, input logic pu, input logic po,
                        input logic c, input logic [15:0] d);
        RST = r; push = pu; pop = po; clearFlags = c; dataIn = d;
        @(posedge CLK);
        #1;
        RST = 1'b0; push = 1'b0; pop = 1'b0; clearFlags = 1'b0;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".count"},     int'(count),     v.cnt);
        chk({tag, ".dataOut"},   int'(dataOut),   int'(v.dout));
        chk({tag, ".empty"},     int'(empty),     int'(v.emp));
        chk({tag, ".full"},      int'(full),      int'(v.ful));
        chk({tag, ".overflow"},  int'(overflow),  int'(v.ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(v.unf));
    endtask

    initial begin
        logic [15:0] exp_top;

        RST = 1'b1; push = 1'b0; pop = 1'b0; clearFlags = 1'b0; dataIn = '0;

        //             rst pu po clr din      cnt dout     emp ful ovf unf
        vecs[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 16'h1111, 1, 16'h1111, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 16'h2222, 2, 16'h2222, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 16'h3333, 3, 16'h3333, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 16'h0000, 2, 16'h2222, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 16'h0000, 1, 16'h1111, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 16'hAAAA, 1, 16'hAAAA, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 16'h5555, 1, 16'h5555, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 16'h7777, 1, 16'h7777, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
        vecs[15] = mk(1, 1, 0, 0, 16'h1234, 0, 16'h0000, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 1, 16'h0000, 0, 16'h0000, 1, 0, 0, 1);
        vecs[17] = mk(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Fill to DEPTH with 0x0000..0x001F.
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, 0, 0, 16'(k));
            chk($sformatf("fill%0d.count", k), int'(count), k + 1);
            chk($sformatf("fill%0d.full", k), int'(full), (k == DEPTH - 1) ? 1 : 0);
        end
        chk("fill.dataOut", int'(dataOut), 16'h001F);

        // Push while full.
        step(0, 1, 0, 0, 16'hBEEF);
        chk("ovpush.count", int'(count), DEPTH);
        chk("ovpush.full",  int'(full), 1);
`ifdef ADDR_STACK_WRAP_EN
        chk("ovpush.dataOut",  int'(dataOut), 16'hBEEF);
        chk("ovpush.overflow", int'(overflow), 0);
`else
        chk("ovpush.dataOut",  int'(dataOut), 16'h001F);
        chk("ovpush.overflow", int'(overflow), 1);
`endif

        // Set-wins-over-clear would matter only on a new event; plain clear here.
        step(0, 0, 0, 1, 16'h0000);
        chk("clr.overflow", int'(overflow), 0);

        // Replace-top while full: no flag, depth unchanged.
        step(0, 1, 1, 0, 16'hCAFE);
        chk("repfull.count",    int'(count), DEPTH);
        chk("repfull.dataOut",  int'(dataOut), 16'hCAFE);
        chk("repfull.overflow", int'(overflow), 0);

        // Drain; top before each pop follows LIFO order of surviving entries.
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 0)
                exp_top = 16'hCAFE;
            else
`ifdef ADDR_STACK_WRAP_EN
                exp_top = 16'(32'h20 - k);
`else
                exp_top = 16'(32'h1F - k);
`endif
            chk($sformatf("drain%0d.dataOut", k), int'(dataOut), int'(exp_top));
            chk($sformatf("drain%0d.count", k), int'(count), DEPTH - k);
            step(0, 0, 1, 0, 16'h0000);
        end
        chk("drain.empty",     int'(empty), 1);
        chk("drain.dataOut",   int'(dataOut), 0);
        chk("drain.underflow", int'(underflow), 0);

        // Hold: no strobes keeps state.
        step(0, 1, 0, 0, 16'h4242);
        step(0, 0, 0, 0, 16'h9999);
        chk("hold.count",   int'(count), 1);
        chk("hold.dataOut", int'(dataOut), 16'h4242);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
